st_matrix_ctrl: RTL and testbench

- Consumer end of the top-level mode state machine's `state` / `state_deep` outputs.
- Decodes the current mode and drives the 8x8 bicolor LED matrix of the light-pen screen.
- Holds the 64-pixel frame buffer and runs a per-pixel probe raster so the light-pen sensor can paint or erase pixels.
- Mode codes come from the shared `st_state.v` macros: RST, STOP, SLEEP, LIGHT, COLOR, ERASE, STATE_0..STATE_3.

---
 rtl/st_matrix_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_st_matrix_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_matrix_ctrl.sv
// rtl/st_matrix_ctrl.sv - 8x8 bicolor light-pen matrix controller (optional macro: ST_PEN_QUAL_EN)
module st_matrix_ctrl #(
  parameter int SUB_CYCLES = 781,
  parameter int PEN_DELAY  = 32,
  parameter int PEN_QUAL   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [2:0] state_deep,
  input  logic       pen,
  output logic [7:0] row_n,
  output logic [7:0] col_r,
  output logic [7:0] col_g,
  output logic [1:0] color_sel,
  output logic [2:0] pen_x,
  output logic [2:0] pen_y,
  output logic       pen_valid
);

  // Mode codes shared with the top-level mode state machine.
  localparam logic [3:0] ST_RST   = 4'd0;
  localparam logic [3:0] ST_STOP  = 4'd1;
  localparam logic [3:0] ST_SLEEP = 4'd2;
  localparam logic [3:0] ST_LIGHT = 4'd3;
  localparam logic [3:0] ST_COLOR = 4'd4;
  localparam logic [3:0] ST_ERASE = 4'd5;

  localparam int SW = (SUB_CYCLES > 2) ? $clog2(SUB_CYCLES) : 1;

  typedef enum logic [2:0] {
    M_RST, M_STOP, M_SLEEP, M_LIGHT, M_COLOR, M_ERASE
  } mode_t;

  // STATE_0..STATE_3 belong to other screens, so they and any unknown code
  // leave the matrix dark and frozen like STOP.
  function automatic mode_t decode(input logic [3:0] s);
    case (s)
      ST_RST:   decode = M_RST;
      ST_STOP:  decode = M_STOP;
      ST_SLEEP: decode = M_SLEEP;
      ST_LIGHT: decode = M_LIGHT;
      ST_COLOR: decode = M_COLOR;
      ST_ERASE: decode = M_ERASE;
      default:  decode = M_STOP;
    endcase
  endfunction

  logic [3:0]    state_prev;
  logic [SW-1:0] sub_cnt;
  logic [2:0]    col;
  logic [2:0]    row;
  logic [1:0]    fb [0:63];
  logic          pen_meta;
  logic          pen_sync;
  logic          hit_flag;

  mode_t cur_mode;
  mode_t disp_mode;
  logic  state_chg;
  logic  sub_last;
  logic  in_window;
  logic  probe;
  logic  qual_now;
  logic  hit_now;
  logic  commit;

  // Only the blink phase bit of state_deep matters on this screen.
  logic unused_deep;
  assign unused_deep = ^state_deep[2:1];

  assign cur_mode  = decode(state);
  assign disp_mode = decode(state_prev);
  assign state_chg = (state != state_prev);
  assign sub_last  = (sub_cnt == SW'(SUB_CYCLES - 1));
  assign in_window = (sub_cnt >= SW'(PEN_DELAY));
  assign probe     = (cur_mode == M_LIGHT) || (cur_mode == M_ERASE);

`ifdef ST_PEN_QUAL_EN
  localparam int QW = $clog2(PEN_QUAL + 1);
  logic [QW-1:0] run_cnt;

  // A qualifying run is the current high sample plus PEN_QUAL-1 earlier ones.
  assign qual_now = in_window && pen_sync && (run_cnt >= QW'(PEN_QUAL - 1));

  // Count consecutive in-window high samples; anything else restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (state_chg || !probe || !in_window || !pen_sync || sub_last) begin
      run_cnt <= '0;
    end else if (run_cnt < QW'(PEN_QUAL)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end
`else
  localparam int unused_pen_qual = PEN_QUAL;
  assign qual_now = in_window && pen_sync;
`endif

  // The sample on the last window cycle still counts toward this subslot.
  assign hit_now = hit_flag || qual_now;
  assign commit  = !state_chg && probe && sub_last && hit_now;

  // Pen synchronizer, mode history and raster position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pen_meta   <= 1'b0;
      pen_sync   <= 1'b0;
      state_prev <= ST_RST;
      sub_cnt    <= '0;
      col        <= 3'd0;
      row        <= 3'd0;
      hit_flag   <= 1'b0;
    end else begin
      pen_meta   <= pen;
      pen_sync   <= pen_meta;
      state_prev <= state;
      if (state_chg) begin
        sub_cnt <= '0;
        col     <= 3'd0;
        row     <= 3'd0;
      end else if (cur_mode != M_STOP) begin
        if (sub_last) begin
          sub_cnt <= '0;
          col     <= col + 3'd1;
          if (col == 3'd7) begin
            row <= row + 3'd1;
          end
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end
      if (state_chg || !probe || sub_last) begin
        hit_flag <= 1'b0;
      end else begin
        hit_flag <= hit_now;
      end
    end
  end

  // Frame buffer: bulk clear in RST, single-pixel paint/erase on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        fb[i] <= 2'b00;
      end
    end else if (cur_mode == M_RST) begin
      for (int i = 0; i < 64; i++) begin
        fb[i] <= 2'b00;
      end
    end else if (commit) begin
      fb[{row, col}] <= (cur_mode == M_LIGHT) ? color_sel : 2'b00;
    end
  end

  // Paint colour steps once per entry into COLOR; hit report pulses on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_sel <= 2'b01;
      pen_x     <= 3'd0;
      pen_y     <= 3'd0;
      pen_valid <= 1'b0;
    end else begin
      if (cur_mode == M_COLOR && disp_mode != M_COLOR) begin
        color_sel <= (color_sel == 2'b11) ? 2'b01 : color_sel + 2'b01;
      end
      pen_valid <= commit;
      if (commit) begin
        pen_x <= col;
        pen_y <= row;
      end
    end
  end

  logic [7:0] row_sel;
  logic [7:0] row_r;
  logic [7:0] row_g;
  logic [1:0] probe_pix;
  logic [7:0] nx_row_n;
  logic [7:0] nx_col_r;
  logic [7:0] nx_col_g;

  // Drive pattern for the position the counters hold, in the mode they ran under.
  always_comb begin
    row_sel   = ~(8'd1 << row);
    probe_pix = fb[{row, col}];
    if (probe_pix == 2'b00) begin
      probe_pix = 2'b10;
    end
    for (int c = 0; c < 8; c++) begin
      row_r[c] = fb[{row, 3'(c)}][0];
      row_g[c] = fb[{row, 3'(c)}][1];
    end
    nx_row_n = 8'hFF;
    nx_col_r = 8'h00;
    nx_col_g = 8'h00;
    case (disp_mode)
      M_RST: begin
        if (!state_deep[0]) begin
          nx_row_n = row_sel;
          nx_col_r = 8'hFF;
        end
      end
      M_SLEEP: begin
        nx_row_n = row_sel;
        nx_col_r = row_r;
        nx_col_g = row_g;
      end
      M_COLOR: begin
        nx_row_n = row_sel;
        nx_col_r = {8{color_sel[0]}};
        nx_col_g = {8{color_sel[1]}};
      end
      M_LIGHT, M_ERASE: begin
        nx_row_n = row_sel;
        nx_col_r = probe_pix[0] ? (8'd1 << col) : 8'h00;
        nx_col_g = probe_pix[1] ? (8'd1 << col) : 8'h00;
      end
      default: begin
        nx_row_n = 8'hFF;
      end
    endcase
  end

  // Matrix drive register, one clock behind the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_n <= 8'hFF;
      col_r <= 8'h00;
      col_g <= 8'h00;
    end else begin
      row_n <= nx_row_n;
      col_r <= nx_col_r;
      col_g <= nx_col_g;
    end
  end

endmodule

// File: tb/tb_st_matrix_ctrl.sv
// tb/tb_st_matrix_ctrl.sv - self-checking bench for st_matrix_ctrl
module tb_st_matrix_ctrl;

  localparam int S  = 16;
  localparam int PD = 4;
  localparam int PQ = 3;

  localparam logic [3:0] ST_RST   = 4'd0;
  localparam logic [3:0] ST_STOP  = 4'd1;
  localparam logic [3:0] ST_SLEEP = 4'd2;
  localparam logic [3:0] ST_LIGHT = 4'd3;
  localparam logic [3:0] ST_COLOR = 4'd4;
  localparam logic [3:0] ST_ERASE = 4'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state;
  logic [2:0] state_deep;
  logic       pen;
  logic [7:0] row_n, col_r, col_g;
  logic [1:0] color_sel;
  logic [2:0] pen_x, pen_y;
  logic       pen_valid;

  st_matrix_ctrl #(.SUB_CYCLES(S), .PEN_DELAY(PD), .PEN_QUAL(PQ)) dut (
    .clk(clk), .rst(rst), .state(state), .state_deep(state_deep), .pen(pen),
    .row_n(row_n), .col_r(col_r), .col_g(col_g), .color_sel(color_sel),
    .pen_x(pen_x), .pen_y(pen_y), .pen_valid(pen_valid)
  );

  always #5 clk = ~clk;

  // Reference model: screen position is elapsed active time t, split by division.
  logic [7:0] e_row_n = 8'hFF, e_col_r = 8'h00, e_col_g = 8'h00;
  logic [1:0] e_csel = 2'b01;
  logic [2:0] e_px = 3'd0, e_py = 3'd0;
  logic       e_pv = 1'b0;
  int         m_fb [64];
  int         m_t = 0, m_prev = 0, m_run = 0;
  bit         m_hit = 0, m_p1 = 0, m_p2 = 0;

  function automatic int mode_of(input int s);
    return (s <= 5) ? s : 1;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) m_fb[i] = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        e_row_n = 8'hFF; e_col_r = 8'h00; e_col_g = 8'h00;
        e_csel = 2'b01; e_px = 3'd0; e_py = 3'd0; e_pv = 1'b0;
        for (int i = 0; i < 64; i++) m_fb[i] = 0;
        m_t = 0; m_prev = 0; m_run = 0; m_hit = 0; m_p1 = 0; m_p2 = 0;
      end else begin
        int sub, col, row, dm, cm, pix, run_n;
        bit chg, probe, win, qual, hitnow, commit;
        logic [7:0] rsel;
        sub = m_t % S;
        col = (m_t / S) % 8;
        row = (m_t / (S * 8)) % 8;
        dm  = mode_of(m_prev);
        cm  = mode_of(int'(state));
        rsel = 8'hFF ^ (8'd1 << row);
        e_row_n = 8'hFF; e_col_r = 8'h00; e_col_g = 8'h00;
        if (dm == 0 && state_deep[0] == 1'b0) begin
          e_row_n = rsel; e_col_r = 8'hFF;
        end else if (dm == 2) begin
          e_row_n = rsel;
          for (int c = 0; c < 8; c++) begin
            e_col_r[c] = m_fb[row * 8 + c][0];
            e_col_g[c] = m_fb[row * 8 + c][1];
          end
        end else if (dm == 4) begin
          e_row_n = rsel;
          e_col_r = e_csel[0] ? 8'hFF : 8'h00;
          e_col_g = e_csel[1] ? 8'hFF : 8'h00;
        end else if (dm == 3 || dm == 5) begin
          e_row_n = rsel;
          pix = (m_fb[row * 8 + col] == 0) ? 2 : m_fb[row * 8 + col];
          if (pix[0]) e_col_r = 8'd1 << col;
          if (pix[1]) e_col_g = 8'd1 << col;
        end
        chg   = (int'(state) != m_prev);
        probe = (cm == 3 || cm == 5);
        win   = (sub >= PD);
        run_n = (win && m_p2) ? m_run + 1 : 0;
`ifdef ST_PEN_QUAL_EN
        qual = win && m_p2 && (run_n >= PQ);
`else
        qual = win && m_p2;
`endif
        hitnow = m_hit || qual;
        commit = !chg && probe && (sub == S - 1) && hitnow;
        e_pv = commit;
        if (commit) begin
          e_px = 3'(col); e_py = 3'(row);
        end
        if (cm == 0) begin
          for (int i = 0; i < 64; i++) m_fb[i] = 0;
        end else if (commit) begin
          m_fb[row * 8 + col] = (cm == 3) ? int'(e_csel) : 0;
        end
        if (cm == 4 && dm != 4) e_csel = (e_csel == 2'd3) ? 2'd1 : e_csel + 2'd1;
        m_hit = (chg || !probe || sub == S - 1) ? 1'b0 : hitnow;
        m_run = (chg || !probe) ? 0 : run_n;
        if (chg) m_t = 0;
        else if (cm != 1) m_t = (m_t + 1) % (64 * S);
        m_prev = int'(state);
        m_p2 = m_p1;
        m_p1 = pen;
      end
    end
  end

  int vec = 0, miss = 0, cyc = 0, ent = 0;
  int pv_cnt = 0;
  logic [2:0] lx = 3'd0, ly = 3'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: compare everything against the model mid-cycle, then step.
  task automatic tick();
    @(negedge clk);
    vec++;
    if ({row_n, col_r, col_g, color_sel, pen_x, pen_y, pen_valid} !==
        {e_row_n, e_col_r, e_col_g, e_csel, e_px, e_py, e_pv}) begin
      miss++;
      $display("FAIL cycle %0d outputs: got row_n=%h r=%h g=%h csel=%0d x=%0d y=%0d v=%b expected row_n=%h r=%h g=%h csel=%0d x=%0d y=%0d v=%b",
               cyc, row_n, col_r, col_g, color_sel, pen_x, pen_y, pen_valid,
               e_row_n, e_col_r, e_col_g, e_csel, e_px, e_py, e_pv);
    end
    if (pen_valid === 1'b1) begin
      pv_cnt++; lx = pen_x; ly = pen_y;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) tick();
  endtask

  task automatic set_state(input logic [3:0] s);
    state = s;
    ent = cyc + 1;
  endtask

  // Make the synchronized pen high for len cycles starting at sub-count s of subslot n.
  task automatic pen_at(input int n, input int s, input int len);
    wait_edge(ent + n * S + s - 2);
    pen = 1'b1;
    wait_edge(ent + n * S + s - 2 + len);
    pen = 1'b0;
  endtask

  localparam logic [1:0] CSEL_SEQ [3] = '{2'b10, 2'b11, 2'b01};
  localparam logic [7:0] CR_SEQ   [3] = '{8'h00, 8'hFF, 8'hFF};
  localparam logic [7:0] CG_SEQ   [3] = '{8'hFF, 8'hFF, 8'h00};

  initial begin
    int pv0;
    rst = 1'b1; state = ST_STOP; state_deep = 3'd0; pen = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("reset row_n", 32'(row_n), 32'hFF);
    chk("reset cols", 32'({col_r, col_g}), 32'h0);
    chk("reset color_sel", 32'(color_sel), 32'h1);
    chk("reset pen_valid", 32'(pen_valid), 32'h0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Empty buffer in SLEEP: rows walk with dark columns.
    set_state(ST_SLEEP);
    wait_edge(ent + 1);
    chk("sleep row0", 32'(row_n), 32'hFE);
    wait_edge(ent + 1 + 7 * 128 + 127);
    chk("sleep row7", 32'(row_n), 32'h7F);
    chk("sleep cols", 32'({col_r, col_g}), 32'h0);
    wait_edge(ent + 1 + 1024);
    chk("sleep wrap", 32'(row_n), 32'hFE);

    // Paint (2,5) red.
    set_state(ST_LIGHT);
    pen_at(21, 6, 4);
    wait_edge(ent + 355);
    chk("light hits", pv_cnt, 1);
    chk("light pen_x", 32'(lx), 32'd5);
    chk("light pen_y", 32'(ly), 32'd2);
    set_state(ST_SLEEP);
    wait_edge(ent + 1 + 2 * 128 + 10);
    chk("painted row_n", 32'(row_n), 32'hFB);
    chk("painted col_r", 32'(col_r), 32'h20);
    chk("painted col_g", 32'(col_g), 32'h00);

    // RST blink phases and buffer clear.
    set_state(ST_RST);
    wait_edge(ent + 1 + 3 * 128 + 2);
    chk("rst deep0 row_n", 32'(row_n), 32'hF7);
    chk("rst deep0 col_r", 32'(col_r), 32'hFF);
    state_deep = 3'd1;
    repeat (200) tick();
    chk("rst deep1 dark", 32'({row_n, col_r, col_g}), 32'hFF0000);
    state_deep = 3'd2;
    repeat (200) tick();
    chk("rst deep2 col_r", 32'(col_r), 32'hFF);
    set_state(ST_SLEEP);
    wait_edge(ent + 1 + 2 * 128 + 10);
    chk("cleared row2", 32'({row_n, col_r, col_g}), 32'hFB0000);

    // Paint again, then erase; an early pulse must not hit.
    set_state(ST_LIGHT);
    pen_at(21, 6, 4);
    wait_edge(ent + 355);
    set_state(ST_ERASE);
    pv0 = pv_cnt;
    pen_at(21, 6, 4);
    pen_at(30, 0, 4);
    wait_edge(ent + 31 * S + 4);
    chk("erase hits", pv_cnt - pv0, 1);
    chk("erase pen_x", 32'(lx), 32'd5);
    set_state(ST_SLEEP);
    wait_edge(ent + 1 + 2 * 128 + 10);
    chk("erased row2", 32'({row_n, col_r, col_g}), 32'hFB0000);

    // Three entries into COLOR.
    for (int i = 0; i < 3; i++) begin
      set_state(ST_SLEEP);
      repeat (5) tick();
      set_state(ST_COLOR);
      wait_edge(ent + 21);
      chk("color_sel", 32'(color_sel), 32'(CSEL_SEQ[i]));
      chk("color col_r", 32'(col_r), 32'(CR_SEQ[i]));
      chk("color col_g", 32'(col_g), 32'(CG_SEQ[i]));
    end

    // STOP and an unknown code both go dark.
    set_state(ST_STOP);
    repeat (10) tick();
    chk("stop dark", 32'({row_n, col_r, col_g}), 32'hFF0000);
    set_state(4'd12);
    repeat (10) tick();
    chk("invalid dark", 32'({row_n, col_r, col_g}), 32'hFF0000);

    // Two-cycle and three-cycle pulses.
    set_state(ST_LIGHT);
    pv0 = pv_cnt;
    pen_at(10, 6, 2);
    pen_at(12, 6, 3);
    wait_edge(ent + 13 * S + 4);
`ifdef ST_PEN_QUAL_EN
    chk("qual hits", pv_cnt - pv0, 1);
`else
    chk("short pulse hits", pv_cnt - pv0, 2);
`endif
    chk("qual pen_x", 32'(lx), 32'd4);

    // Asynchronous reset in the middle of LIGHT.
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("async row_n", 32'(row_n), 32'hFF);
    chk("async cols", 32'({col_r, col_g}), 32'h0);
    chk("async pen", 32'({pen_x, pen_y, pen_valid}), 32'h0);
    chk("async color_sel", 32'(color_sel), 32'h1);
    repeat (3) tick();
    rst = 1'b1;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
